seg7_scan_decoder: RTL and testbench

Receive-side companion to the registered hex-to-7-segment encoder: samples a time-multiplexed, active-low 7-segment display bus (segment lines plus per-digit enables), filters it for stability, and decodes each digit's pattern back to a 4-bit hex value. It sits behind the display pins in loop-back and self-test builds, and feeds the UART transmit path with the decoded digits. Each digit has a value register, a validity flag and a one-cycle update strobe; unrecognised patterns are flagged.

---
 rtl/seg7_scan_decoder.sv | 159 +++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Receive-side decoder for a multiplexed active-low 7-segment bus: synchronizes,
// debounces and decodes each digit back to hex with per-digit valid and update strobes.
module seg7_scan_decoder #(
  parameter  int NUM_DIGITS    = 4,
  parameter  int STABLE_CYCLES = 4,
  localparam int IW            = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    upd_valid,
  output logic [IW-1:0]           upd_index,
  output logic [3:0]              upd_value,
  output logic                    err
);

  localparam int         SW      = NUM_DIGITS + 7;
  localparam logic [7:0] CNT_SAT = 8'(STABLE_CYCLES);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_HELD  = 2'd2;

  logic [SW-1:0]                 r_sync1, r_sync2, r_last;
  logic [7:0]                    r_cnt;
  logic [1:0]                    r_state;
  logic [NUM_DIGITS-1:0][3:0]    r_dig;
  logic [NUM_DIGITS-1:0]         r_vld;
  logic                          r_upd_valid, r_err;
  logic [IW-1:0]                 r_upd_index;
  logic [3:0]                    r_upd_value;

  logic [SW-1:0]         w_sample;
  logic                  w_same, w_commit;
  logic [NUM_DIGITS-1:0] w_en_h;
  logic [6:0]            w_p;
  logic                  w_onehot, w_multi, w_hit;
  logic [3:0]            w_val;
  logic [IW-1:0]         w_idx;
  logic [NUM_DIGITS-1:0] w_sel;

  function automatic logic [4:0] f_decode(input logic [6:0] p);
    logic [4:0] d;
    case (p)
      7'b0111111: d = 5'h10;
      7'b0000110: d = 5'h11;
      7'b1011011: d = 5'h12;
      7'b1001111: d = 5'h13;
      7'b1100110: d = 5'h14;
      7'b1101101: d = 5'h15;
      7'b1111101: d = 5'h16;
      7'b0000111: d = 5'h17;
      7'b1111111: d = 5'h18;
      7'b1101111: d = 5'h19;
      7'b1110111: d = 5'h1A;
      7'b1111100: d = 5'h1B;
      7'b0111001: d = 5'h1C;
      7'b1011110: d = 5'h1D;
      7'b1111001: d = 5'h1E;
      7'b1110001: d = 5'h1F;
      default:    d = 5'h00;
    endcase
    return d;
  endfunction

  // Both sync flops idle high so reset looks like a blanked bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= '1;
      r_sync2 <= '1;
    end else begin
      r_sync1 <= {dig_en, seg_in};
      r_sync2 <= r_sync1;
    end
  end

  assign w_sample = r_sync2;
  assign w_same   = (w_sample == r_last);
  assign w_commit = w_same && (r_state == S_TRACK) && (r_cnt == CNT_SAT - 8'd1);

  // cnt starts saturated so the idle bus after reset never commits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last  <= '1;
      r_cnt   <= CNT_SAT;
      r_state <= S_IDLE;
    end else if (!w_same) begin
      r_last  <= w_sample;
      r_cnt   <= 8'd1;
      r_state <= S_TRACK;
    end else if (r_cnt < CNT_SAT) begin
      r_cnt <= r_cnt + 8'd1;
      if (w_commit) r_state <= S_HELD;
    end
  end

  assign w_en_h   = ~w_sample[SW-1:7];
  assign w_p      = ~w_sample[6:0];
  assign w_onehot = $onehot(w_en_h);
  assign w_multi  = (w_en_h != '0) && !w_onehot;
  assign {w_hit, w_val} = f_decode(w_p);

  always_comb begin
    w_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (w_en_h[i]) w_idx = IW'(i);
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign w_sel[g] = w_commit && w_onehot && w_en_h[g];

    // Blank or illegal pattern drops validity but keeps the last value.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_dig[g] <= 4'h0;
        r_vld[g] <= 1'b0;
      end else if (w_sel[g]) begin
        r_vld[g] <= w_hit;
        if (w_hit) r_dig[g] <= w_val;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_upd_valid <= 1'b0;
      r_err       <= 1'b0;
      r_upd_index <= '0;
      r_upd_value <= 4'h0;
    end else begin
      r_upd_valid <= 1'b0;
      r_err       <= 1'b0;
      if (w_commit) begin
        if (w_multi) begin
          r_err <= 1'b1;
        end else if (w_onehot) begin
          if (w_hit) begin
            r_upd_valid <= 1'b1;
            r_upd_index <= w_idx;
            r_upd_value <= w_val;
          end else if (w_p != 7'd0) begin
            r_err <= 1'b1;
          end
        end
      end
    end
  end

  assign digits_out  = r_dig;
  assign digit_valid = r_vld;
  assign upd_valid   = r_upd_valid;
  assign upd_index   = r_upd_index;
  assign upd_value   = r_upd_value;
  assign err         = r_err;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Directed bench for seg7_scan_decoder: latency, scan, error, glitch and reset cases,
// with a table of bus patterns and hand-computed register contents.
module tb_seg7_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [6:0]  seg_in = '1;
  logic [3:0]  dig_en = '1;
  logic [15:0] digits_out;
  logic [3:0]  digit_valid;
  logic        upd_valid;
  logic [1:0]  upd_index;
  logic [3:0]  upd_value;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;
  int n_upd = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .seg_in(seg_in), .dig_en(dig_en),
    .digits_out(digits_out), .digit_valid(digit_valid), .upd_valid(upd_valid),
    .upd_index(upd_index), .upd_value(upd_value), .err(err)
  );

  typedef struct {
    logic [3:0]  en;
    logic [6:0]  p;
    int          cyc;
    int          nu;
    int          ne;
    logic [1:0]  idx;
    logic [3:0]  val;
    logic [15:0] dig;
    logic [3:0]  vld;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic [3:0] en, input logic [6:0] p, input int cyc,
                              input int nu, input int ne, input logic [1:0] idx,
                              input logic [3:0] val, input logic [15:0] dig,
                              input logic [3:0] vld);
    vec_t v;
    v.en = en; v.p = p; v.cyc = cyc; v.nu = nu; v.ne = ne;
    v.idx = idx; v.val = val; v.dig = dig; v.vld = vld;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic hold(input logic [3:0] en, input logic [6:0] p, input int n);
    dig_en = en;
    seg_in = ~p;
    repeat (n) @(negedge clk);
  endtask

  // Pulse monitor sampled just after each active edge.
  always @(posedge clk) begin
    #1;
    if (upd_valid) n_upd++;
    if (err) n_err++;
    n_cmp++;
    if (upd_valid && err) begin
      n_bad++;
      $display("FAIL excl: upd_valid=%0b err=%0b both high", upd_valid, err);
    end
  end

  initial begin
    // Bus table: blanks are en=1111; register expectations are cumulative.
    vt.push_back(mk(4'b1111, 7'b0000000,  2, 0, 0, 2'd0, 4'h0, 16'h0002, 4'b0001));
    vt.push_back(mk(4'b1110, 7'b0000110, 10, 1, 0, 2'd0, 4'h1, 16'h0001, 4'b0001));
    vt.push_back(mk(4'b1111, 7'b0000000,  2, 0, 0, 2'd0, 4'h0, 16'h0001, 4'b0001));
    vt.push_back(mk(4'b1101, 7'b1110111, 10, 1, 0, 2'd1, 4'hA, 16'h00A1, 4'b0011));
    vt.push_back(mk(4'b1111, 7'b0000000,  2, 0, 0, 2'd0, 4'h0, 16'h00A1, 4'b0011));
    vt.push_back(mk(4'b1011, 7'b1110001, 10, 1, 0, 2'd2, 4'hF, 16'h0FA1, 4'b0111));
    vt.push_back(mk(4'b1111, 7'b0000000,  2, 0, 0, 2'd0, 4'h0, 16'h0FA1, 4'b0111));
    vt.push_back(mk(4'b0111, 7'b1111111, 10, 1, 0, 2'd3, 4'h8, 16'h8FA1, 4'b1111));
    vt.push_back(mk(4'b1111, 7'b0000000,  2, 0, 0, 2'd0, 4'h0, 16'h8FA1, 4'b1111));
    vt.push_back(mk(4'b1101, 7'b0101010,  8, 0, 1, 2'd0, 4'h0, 16'h8FA1, 4'b1101));
    vt.push_back(mk(4'b1111, 7'b0000000,  2, 0, 0, 2'd0, 4'h0, 16'h8FA1, 4'b1101));
    // Same digit/pattern after a blank commits again.
    vt.push_back(mk(4'b1110, 7'b0000110,  8, 1, 0, 2'd0, 4'h1, 16'h8FA1, 4'b1101));
    // 3-cycle glitch to '7' never commits; the restored pattern re-commits '1'.
    vt.push_back(mk(4'b1110, 7'b0000111,  3, 0, 0, 2'd0, 4'h0, 16'h8FA1, 4'b1101));
    vt.push_back(mk(4'b1110, 7'b0000110,  8, 1, 0, 2'd0, 4'h1, 16'h8FA1, 4'b1101));
    vt.push_back(mk(4'b1111, 7'b0000000,  2, 0, 0, 2'd0, 4'h0, 16'h8FA1, 4'b1101));
    vt.push_back(mk(4'b1110, 7'b0000000,  8, 0, 0, 2'd0, 4'h0, 16'h8FA1, 4'b1100));
    vt.push_back(mk(4'b1100, 7'b1111111,  8, 0, 1, 2'd0, 4'h0, 16'h8FA1, 4'b1100));
    vt.push_back(mk(4'b1111, 7'b0000000,  2, 0, 0, 2'd0, 4'h0, 16'h8FA1, 4'b1100));
    vt.push_back(mk(4'b1011, 7'b0111001,  8, 1, 0, 2'd2, 4'hC, 16'h8CA1, 4'b1100));
    vt.push_back(mk(4'b1111, 7'b0000000,  2, 0, 0, 2'd0, 4'h0, 16'h8CA1, 4'b1100));
    vt.push_back(mk(4'b1110, 7'b1011110,  8, 1, 0, 2'd0, 4'hD, 16'h8CAD, 4'b1101));

    #3 rst_n = 1'b0;
    #1;
    chk("rst_digits", 32'(digits_out), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_upd", 32'(upd_valid), 32'h0);
    chk("rst_idx", 32'(upd_index), 32'h0);
    chk("rst_val", 32'(upd_value), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n_upd = 0; n_err = 0;
    repeat (100) @(negedge clk);
    chk("idle_upd", 32'(n_upd), 32'd0);
    chk("idle_err", 32'(n_err), 32'd0);
    chk("idle_digits", 32'(digits_out), 32'h0);
    chk("idle_valid", 32'(digit_valid), 32'h0);

    // Latency: pulse appears after the 6th edge (k=5) and lasts one cycle.
    n_upd = 0; n_err = 0;
    dig_en = 4'b1110;
    seg_in = ~7'b1011011;
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      chk($sformatf("lat_upd_k%0d", k), 32'(upd_valid), (k == 5) ? 32'd1 : 32'd0);
      if (k == 5) begin
        chk("lat_idx", 32'(upd_index), 32'd0);
        chk("lat_val", 32'(upd_value), 32'd2);
      end
    end
    chk("lat_nupd", 32'(n_upd), 32'd1);
    chk("lat_nerr", 32'(n_err), 32'd0);
    chk("lat_digits", 32'(digits_out), 32'h0002);
    chk("lat_valid", 32'(digit_valid), 32'b0001);

    foreach (vt[i]) begin
      n_upd = 0; n_err = 0;
      hold(vt[i].en, vt[i].p, vt[i].cyc);
      chk($sformatf("v%0d_nupd", i), 32'(n_upd), 32'(vt[i].nu));
      chk($sformatf("v%0d_nerr", i), 32'(n_err), 32'(vt[i].ne));
      chk($sformatf("v%0d_digits", i), 32'(digits_out), 32'(vt[i].dig));
      chk($sformatf("v%0d_valid", i), 32'(digit_valid), 32'(vt[i].vld));
      if (vt[i].nu > 0) begin
        chk($sformatf("v%0d_idx", i), 32'(upd_index), 32'(vt[i].idx));
        chk($sformatf("v%0d_val", i), 32'(upd_value), 32'(vt[i].val));
      end
    end

    // Reset asserted mid-TRACK clears outputs without waiting for a clock.
    n_upd = 0; n_err = 0;
    hold(4'b1101, 7'b1001111, 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_digits", 32'(digits_out), 32'h0);
    chk("mid_rst_valid", 32'(digit_valid), 32'h0);
    chk("mid_rst_upd", 32'(upd_valid), 32'h0);
    chk("mid_rst_err", 32'(err), 32'h0);
    dig_en = '1;
    seg_in = '1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n_upd = 0; n_err = 0;
    repeat (20) @(negedge clk);
    chk("post_rst_nupd", 32'(n_upd), 32'd0);
    chk("post_rst_nerr", 32'(n_err), 32'd0);
    chk("post_rst_digits", 32'(digits_out), 32'h0);
    chk("post_rst_valid", 32'(digit_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
